// File: rtl/uart_program_loader.sv
// UART program loader: deserialises rx bytes, packs them little-endian into 32-bit words and
// writes consecutive instruction-memory words. Define UART_PARITY_EN to expect an even-parity bit.
module uart_program_loader #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              fpga_clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        err
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_e;

    rx_state_e         state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, rx_d1_q, rx_d1_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrapped_q, wrapped_d;
    logic              got_byte_q, got_byte_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              load_done_q, load_done_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [2:0]        err_q, err_d;
    logic              fall_s, byte_valid_s, frame_err_s, par_bad_s;

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    assign par_bad_s = par_err_q;
`else
    assign par_bad_s = 1'b0;
`endif

    // Synchroniser, receive FSM and frame timing.
    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        rx_d1_d      = sync2_q;
        fall_s       = rx_d1_q & ~sync2_q;
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fall_s && !load_done_q) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    par_err_d = (sync2_q != even_parity(shift_q));
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (sync2_q && !par_bad_s) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Word assembly, memory write, wrap/saturation and idle-timeout bookkeeping.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        ptr_d        = ptr_q;
        wrapped_d    = wrapped_q;
        got_byte_d   = got_byte_q;
        tmo_d        = tmo_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_done_d  = load_done_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        if (start) begin
            byte_idx_d   = 2'd0;
            ptr_d        = '0;
            wrapped_d    = 1'b0;
            got_byte_d   = 1'b0;
            tmo_d        = '0;
            load_done_d  = 1'b0;
            word_count_d = '0;
            err_d        = 3'b000;
        end else if (load_done_q) begin
            load_done_d = 1'b1;
        end else begin
            if (frame_err_s) begin
                err_d[0] = 1'b1;
            end else begin
                err_d[0] = err_q[0];
            end
            if (byte_valid_s) begin
                got_byte_d = 1'b1;
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: word_buf_d[7:0]   = shift_q;
                    2'd1: word_buf_d[15:8]  = shift_q;
                    2'd2: word_buf_d[23:16] = shift_q;
                    2'd3: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = {shift_q, word_buf_q};
                        ptr_d     = ptr_q + ADDR_W'(1);
                        // A write after the pointer has wrapped overwrites earlier words.
                        if (wrapped_q) begin
                            err_d[2] = 1'b1;
                        end else begin
                            err_d[2] = err_q[2];
                        end
                        if (ptr_q == PTR_MAX) begin
                            wrapped_d = 1'b1;
                        end else begin
                            wrapped_d = wrapped_q;
                        end
                        if (word_count_q != COUNT_MAX) begin
                            word_count_d = word_count_q + (ADDR_W+1)'(1);
                        end else begin
                            word_count_d = word_count_q;
                        end
                    end
                    default: word_buf_d = word_buf_q;
                endcase
            end else begin
                got_byte_d = got_byte_q;
            end
            if (fall_s) begin
                tmo_d = '0;
            end else if (got_byte_q) begin
                if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    load_done_d = 1'b1;
                    if (byte_idx_q != 2'd0) begin
                        err_d[1]   = 1'b1;
                        byte_idx_d = 2'd0;
                    end else begin
                        err_d[1] = err_q[1];
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_d = tmo_q;
            end
        end
    end

    // State register; synchroniser stages reset to the idle-high line level.
    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_d1_q      <= 1'b1;
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_idx_q   <= 2'd0;
            word_buf_q   <= 24'h000000;
            ptr_q        <= '0;
            wrapped_q    <= 1'b0;
            got_byte_q   <= 1'b0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'h00000000;
            load_done_q  <= 1'b0;
            word_count_q <= '0;
            err_q        <= 3'b000;
`ifdef UART_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            rx_d1_q      <= rx_d1_d;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            ptr_q        <= ptr_d;
            wrapped_q    <= wrapped_d;
            got_byte_q   <= got_byte_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
`ifdef UART_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a 14-bit-address instance and a 2-bit-address
// instance share rx/start/reset; write strobes of both are logged for checking.
module tb_uart_program_loader;
    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic        wr_en_a, wr_en_b, load_done_a, load_done_b;
    logic [13:0] wr_addr_a;
    logic [1:0]  wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic [14:0] word_count_a;
    logic [2:0]  word_count_b;
    logic [2:0]  err_a, err_b;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wcnt_a = 0;
    int          wcnt_b = 0;
    logic [31:0] wdata_a [64];
    logic [31:0] waddr_a [64];
    logic [31:0] wdata_b [64];
    logic [31:0] waddr_b [64];

    always #5 clk = ~clk;

    uart_program_loader #(.CLK_FREQ(1600000), .BAUD(100000), .ADDR_W(14), .TIMEOUT_CYC(400)) u_dut_a (
        .fpga_clk(clk), .reset(reset), .rx(rx), .start(start), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .load_done(load_done_a), .word_count(word_count_a), .err(err_a));

    uart_program_loader #(.CLK_FREQ(1600000), .BAUD(100000), .ADDR_W(2), .TIMEOUT_CYC(400)) u_dut_b (
        .fpga_clk(clk), .reset(reset), .rx(rx), .start(start), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .load_done(load_done_b), .word_count(word_count_b), .err(err_b));

    // Write logger, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_en_a) begin
            if (wcnt_a < 64) begin
                waddr_a[wcnt_a] <= 32'(wr_addr_a);
                wdata_a[wcnt_a] <= wr_data_a;
            end
            wcnt_a <= wcnt_a + 1;
        end
        if (wr_en_b) begin
            if (wcnt_b < 64) begin
                waddr_b[wcnt_b] <= 32'(wr_addr_b);
                wdata_b[wcnt_b] <= wr_data_b;
            end
            wcnt_b <= wcnt_b + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx = ^b;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

`ifdef UART_PARITY_EN
    task automatic send_byte_badpar(input logic [7:0] b);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = ~(^b);
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
    endtask
`endif

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (load_done_a) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   base_a;
        int   base_b;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_wr_en", 32'(wr_en_a), 32'd0);
        check_val("rst_wr_data", wr_data_a, 32'd0);
        check_val("rst_load_done", 32'(load_done_a), 32'd0);
        check_val("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Two full words, then idle timeout
        base_a = wcnt_a;
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        check_val("t1_early_done", 32'(load_done_a), 32'd0);
        wait_done(404, seen);
        check_val("t1_done", 32'(seen), 32'd1);
        check_val("t1_nwrites", 32'(wcnt_a - base_a), 32'd2);
        check_val("t1_addr0", waddr_a[base_a], 32'd0);
        check_val("t1_data0", wdata_a[base_a], 32'h00100093);
        check_val("t1_addr1", waddr_a[base_a + 1], 32'd1);
        check_val("t1_data1", wdata_a[base_a + 1], 32'h00000013);
        check_val("t1_count", 32'(word_count_a), 32'd2);
        check_val("t1_err", 32'(err_a), 32'd0);

        // rx ignored while done
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        check_val("t1_ignored_writes", 32'(wcnt_a - base_a), 32'd2);
        check_val("t1_ignored_count", 32'(word_count_a), 32'd2);

        // Frame error drops a byte, trailing partial word flagged at timeout
        pulse_start();
        base_a = wcnt_a;
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b0);
        check_val("t2_frame_err", 32'(err_a), 32'd1);
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1);
        check_val("t2_nwrites", 32'(wcnt_a - base_a), 32'd1);
        check_val("t2_addr0", waddr_a[base_a], 32'd0);
        check_val("t2_data0", wdata_a[base_a], 32'h00100093);
        wait_done(404, seen);
        check_val("t2_done", 32'(seen), 32'd1);
        check_val("t2_err", 32'(err_a), 32'd3);
        check_val("t2_count", 32'(word_count_a), 32'd1);

        // Restart clears session state
        pulse_start();
        check_val("t3_err_clr", 32'(err_a), 32'd0);
        check_val("t3_done_clr", 32'(load_done_a), 32'd0);
        check_val("t3_count_clr", 32'(word_count_a), 32'd0);
        base_a = wcnt_a;
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        check_val("t3_nwrites", 32'(wcnt_a - base_a), 32'd1);
        check_val("t3_addr0", waddr_a[base_a], 32'd0);
        check_val("t3_data0", wdata_a[base_a], 32'h00000013);
        check_val("t3_count", 32'(word_count_a), 32'd1);

        // Reset mid-frame
        pulse_start();
        rx = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("t4_rst_data", wr_data_a, 32'd0);
        check_val("t4_rst_count", 32'(word_count_a), 32'd0);
        check_val("t4_rst_wr_en", 32'(wr_en_a), 32'd0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        base_a = wcnt_a;
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        check_val("t4_nwrites", 32'(wcnt_a - base_a), 32'd1);
        check_val("t4_addr0", waddr_a[base_a], 32'd0);
        check_val("t4_data0", wdata_a[base_a], 32'h00100093);

        // Short low glitch is rejected
        pulse_start();
        base_a = wcnt_a;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (600) @(negedge clk);
        check_val("t5_done", 32'(load_done_a), 32'd0);
        check_val("t5_nwrites", 32'(wcnt_a - base_a), 32'd0);
        check_val("t5_count", 32'(word_count_a), 32'd0);
        check_val("t5_err", 32'(err_a), 32'd0);

        // Address wrap on the 2-bit instance
        pulse_start();
        base_b = wcnt_b;
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(w * 17), 1'b1);
        end
        check_val("t6_err_pre_wrap", 32'(err_b), 32'd0);
        check_val("t6_addr3", waddr_b[base_b + 3], 32'd3);
        for (int k = 0; k < 4; k++) send_byte(8'h55, 1'b1);
        check_val("t6_nwrites", 32'(wcnt_b - base_b), 32'd5);
        check_val("t6_addr4", waddr_b[base_b + 4], 32'd0);
        check_val("t6_data4", wdata_b[base_b + 4], 32'h55555555);
        check_val("t6_err", 32'(err_b), 32'd4);
        check_val("t6_count", 32'(word_count_b), 32'd4);

`ifdef UART_PARITY_EN
        // Wrong parity drops the byte
        pulse_start();
        base_a = wcnt_a;
        send_byte_badpar(8'h93);
        check_val("t7_par_err", 32'(err_a), 32'd1);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        check_val("t7_nwrites", 32'(wcnt_a - base_a), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
